// File: rtl/probe_window_scheduler.sv
// Differential-fuzzing capture window sequencer for a DUT/variant core pair.
// Tracks enqueue divergence to end-marker commit and arbitrates probe writes.
module probe_window_scheduler #(
  parameter int          NUM_REQ = 4,
  parameter int          DATA_W  = 64,
  parameter logic [31:0] MARKER  = 32'h00302013,
  parameter int          TIMEOUT = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dut_enq_valid,
  input  logic [31:0]               dut_enq_inst,
  input  logic                      vnt_enq_valid,
  input  logic [31:0]               vnt_enq_inst,
  input  logic                      dut_cmt_valid,
  input  logic [31:0]               dut_cmt_inst,
  input  logic                      vnt_cmt_valid,
  input  logic [31:0]               vnt_cmt_inst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pb_wen,
  output logic [DATA_W-1:0]         pb_write,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      timed_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic          dut_done;
  logic          vnt_done;
  logic [TW-1:0] timer;
  logic [IW-1:0] rr_ptr;

  logic          diverge;
  logic          dut_hit;
  logic          vnt_hit;
  logic          dut_fin;
  logic          vnt_fin;
  logic          core_fin;
  logic          time_up;

  logic              arb_en;
  logic              gnt_any;
  logic [IW-1:0]     gnt_idx;
  logic [DATA_W-1:0] sel_data;

  // Idle slots on both sides compare equal regardless of inst.
  assign diverge = (dut_enq_valid != vnt_enq_valid) ||
                   (dut_enq_valid && vnt_enq_valid &&
                    (dut_enq_inst != vnt_enq_inst));

  assign dut_hit  = dut_cmt_valid && (dut_cmt_inst == MARKER);
  assign vnt_hit  = vnt_cmt_valid && (vnt_cmt_inst == MARKER);
  assign dut_fin  = dut_done | dut_hit;
  assign vnt_fin  = vnt_done | vnt_hit;
  assign core_fin = dut_fin & vnt_fin;
  assign time_up  = (timer == TW'(TIMEOUT - 1));

  assign arb_en = (state != S_DONE);

  // Rotating search starting just past the last winner.
  always_comb begin
    int            j;
    logic [IW-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    j       = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j    = (int'(rr_ptr) + k) % NUM_REQ;
      cand = IW'(j);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!arb_en) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= IW'(NUM_REQ - 1);
      pb_wen   <= 1'b0;
      pb_write <= '0;
    end else begin
      pb_wen <= gnt_any;
      if (gnt_any) begin
        rr_ptr   <= gnt_idx;
        pb_write <= sel_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_SYNC;
      done      <= 1'b0;
      timed_out <= 1'b0;
      dut_done  <= 1'b0;
      vnt_done  <= 1'b0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_SYNC: begin
          if (diverge) begin
            state <= S_DIV;
            timer <= '0;
          end
        end
        S_DIV: begin
          dut_done <= dut_fin;
          vnt_done <= vnt_fin;
          timer    <= timer + 1'b1;
          // A marker pair landing on the last timer cycle still wins.
          if (core_fin) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (time_up) begin
            state     <= S_DONE;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
